// File: rtl/prco_bootloader.sv
// rtl/prco_bootloader.sv - UART frame loader that fills instruction memory and releases the core
// Frame: MAGIC, len_hi, len_lo, len x (hi, lo), 8-bit sum of data bytes.
module prco_bootloader #(
    parameter logic [7:0] MAGIC     = 8'hA5,
    parameter int         MAX_WORDS = 1024,
    parameter int         TIMEOUT   = 1000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_valid,
    input  logic [7:0]  i_rx_data,
    output logic        q_rx_ready,
    output logic        q_mem_we,
    output logic [15:0] q_mem_addr,
    output logic [15:0] q_mem_dina,
    output logic        q_core_reset,
    output logic        q_core_en,
    output logic        q_ack_valid,
    output logic [7:0]  q_ack_data,
    input  logic        i_ack_ready,
    output logic        q_done,
    output logic        q_error,
    output logic [1:0]  q_err_code
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM, RESP, RUN
    } state_t;

    state_t state, next_state;

    logic [TW-1:0] timer;
    logic [7:0]    len_hi;
    logic [15:0]   word_len;
    logic [15:0]   word_addr;
    logic [7:0]    hi_byte;
    logic [7:0]    csum;

    logic          accept;
    logic          ack_fire;
    logic          in_frame;
    logic          timed_out;
    logic [15:0]   frame_len;
    logic          set_err;
    logic [1:0]    err_next;
    logic          resp_ok;

    assign in_frame     = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                          (state == DATA_LO) || (state == CSUM);
    assign q_rx_ready   = (state == IDLE) || in_frame;
    assign q_ack_valid  = (state == RESP);
    assign q_core_reset = (state != RUN);
    assign q_core_en    = (state == RUN);
    assign q_done       = (state == RUN);

    assign accept    = i_rx_valid & q_rx_ready;
    assign ack_fire  = q_ack_valid & i_ack_ready;
    assign frame_len = {len_hi, i_rx_data};
    // An accepted byte always wins over an expiring timer.
    assign timed_out = in_frame && !accept && (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        set_err    = 1'b0;
        err_next   = 2'd0;
        resp_ok    = 1'b0;
        case (state)
            IDLE: begin
                if (accept && i_rx_data == MAGIC) begin
                    next_state = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    next_state = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    if ({1'b0, frame_len} > 17'(MAX_WORDS)) begin
                        next_state = RESP;
                        set_err    = 1'b1;
                        err_next   = 2'd1;
                    end else if (frame_len == 16'd0) begin
                        next_state = CSUM;
                    end else begin
                        next_state = DATA_HI;
                    end
                end
            end
            DATA_HI: begin
                if (accept) begin
                    next_state = DATA_LO;
                end
            end
            DATA_LO: begin
                if (accept) begin
                    next_state = (word_addr + 16'd1 == word_len) ? CSUM : DATA_HI;
                end
            end
            CSUM: begin
                if (accept) begin
                    next_state = RESP;
                    if (i_rx_data == csum) begin
                        resp_ok = 1'b1;
                    end else begin
                        set_err  = 1'b1;
                        err_next = 2'd2;
                    end
                end
            end
            RESP: begin
                if (ack_fire) begin
                    next_state = q_error ? IDLE : RUN;
                end
            end
            RUN: begin
                next_state = RUN;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        if (timed_out) begin
            next_state = RESP;
            set_err    = 1'b1;
            err_next   = 2'd3;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            timer      <= '0;
            len_hi     <= 8'd0;
            word_len   <= 16'd0;
            word_addr  <= 16'd0;
            hi_byte    <= 8'd0;
            csum       <= 8'd0;
            q_mem_we   <= 1'b0;
            q_mem_addr <= 16'd0;
            q_mem_dina <= 16'd0;
            q_ack_data <= 8'd0;
            q_error    <= 1'b0;
            q_err_code <= 2'd0;
        end else begin
            q_mem_we <= 1'b0;

            if (in_frame && !accept) begin
                timer <= timer + TW'(1);
            end else begin
                timer <= '0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (i_rx_data == MAGIC) begin
                            csum       <= 8'd0;
                            word_addr  <= 16'd0;
                            q_error    <= 1'b0;
                            q_err_code <= 2'd0;
                        end
                    end
                    LEN_HI:  len_hi   <= i_rx_data;
                    LEN_LO:  word_len <= frame_len;
                    DATA_HI: begin
                        hi_byte <= i_rx_data;
                        csum    <= csum + i_rx_data;
                    end
                    DATA_LO: begin
                        csum       <= csum + i_rx_data;
                        q_mem_we   <= 1'b1;
                        q_mem_addr <= word_addr;
                        q_mem_dina <= {hi_byte, i_rx_data};
                        word_addr  <= word_addr + 16'd1;
                    end
                    default: begin
                    end
                endcase
            end

            if (set_err) begin
                q_error    <= 1'b1;
                q_err_code <= err_next;
                q_ack_data <= 8'h15;
            end else if (resp_ok) begin
                q_ack_data <= 8'h06;
            end
        end
    end

endmodule
